// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver.
// Both ends import the same defaults so their bit periods agree.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TIMER_WIDTH = 8;

endpackage

// File: rtl/serial_bit_timer.sv
// Free-running bit-period counter; bit_end marks the last cycle of each period.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int TimerWidth = DEF_TIMER_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  logic [TimerWidth-1:0] count;

  // Wraps naturally at 2^TimerWidth, so back-to-back bits need no explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = &count;

endmodule

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, stop bit(s),
// with a one-entry holding register so frames can run back to back.
module serial_tx
  import serial_pkg::*;
#(
  parameter int Width      = DEF_WIDTH,
  parameter int TimerWidth = DEF_TIMER_WIDTH,
  parameter int StopBits   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] D,
  input  logic             send,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             finish
);

  localparam int CntW = (Width > 1) ? $clog2(Width) : 1;

  state_e            state_q, state_d;
  logic [Width-1:0]  hold_q;
  logic              hold_full_q, hold_full_d;
  logic [Width-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              finish_q, finish_d;
  logic              bit_end;
  logic              accept;
  logic              load;

  serial_bit_timer #(
    .TimerWidth(TimerWidth)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .bit_end(bit_end)
  );

  assign accept = send && !hold_full_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    finish_d   = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        load = hold_full_q;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == CntW'(Width - 1)) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'(StopBits - 1)) begin
            finish_d = 1'b1;
            state_d  = IDLE;
            load     = hold_full_q;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A full holding register restarts the shifter without an idle cycle.
    if (load) begin
      state_d = START;
      shreg_d = hold_q;
    end

    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      finish_q    <= finish_d;
    end
  end

  // Data registers carry no reset; the control flags decide when they are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= D;
    end
    shreg_q <= shreg_d;
  end

  assign ready  = !hold_full_q;
  assign busy   = (state_q != IDLE);
  assign tx     = tx_q;
  assign finish = finish_q;

endmodule

// File: doc/serial_tx.md
# serial_tx

Asynchronous serial transmitter, the transmit counterpart of the codebase's serial receiver. It frames parallel words as 1 start bit (0), `Width` data bits LSB first, and `StopBits` stop bits (1), with a fixed bit period of 2^`TimerWidth` clock cycles. A one-entry holding register lets the producer queue the next word while the current frame shifts out, so consecutive frames need no idle gap. It sits between the on-chip producer and the `tx` pad.

## Interface
Parameters:
- `Width`, 8, data bits per frame (≥1)
- `TimerWidth`, 8, bit period = 2^`TimerWidth` clk cycles; must equal the receiver's setting
- `StopBits`, 1, number of stop bits, 1 or 2

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `D`  in  `Width`  word to transmit, sampled on acceptance
- `send`  in  1  producer valid
- `ready`  out  1  holding register empty; word accepted on an edge where `send && ready`
- `tx`  out  1  serial line, registered, idle high
- `busy`  out  1  shifter active (frame in progress)
- `finish`  out  1  one-cycle pulse after the last stop-bit cycle of each frame

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `finish`=0; holding register empty; state IDLE; timer and bit counter 0.
- Acceptance: at an edge with `send && ready`, `D` → holding register and `ready` → 0. `send` while `ready`=0 is ignored; `D` is not re-sampled.
- Shifter load: at any edge where the shifter is free (IDLE, or the final cycle of the last stop bit) and the holding register is full, the word moves into the shifter, the holding register empties (`ready` → 1), state → START, and `tx` → 0.
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current LSB; shift right each bit period; bit counter 0..`Width`-1.
  - STOP: `tx`=1; `StopBits` periods.
  - Each state holds for full bit periods. The timer counts 0..2^`TimerWidth`-1 and wraps to 0 on each bit boundary.
- End of frame: on the final STOP cycle edge, `finish` is set for one cycle. The next state is START if the holding register is full, otherwise IDLE.
- `busy` = state ≠ IDLE.
- Simultaneous acceptance and frame end (holding register empty, `send` at the final STOP edge): the word enters the holding register at that edge and loads into the shifter on the next edge. `tx` shows exactly one extra idle-high cycle.
- Holding full with `send` asserted on the drain edge: not accepted (`ready` was 0). It is accepted on the following edge.
- Reset mid-frame: at the reset edge, `tx` → 1 and the frame and holding word are discarded. No `finish` is generated.

## Timing
- Acceptance edge N from IDLE: holding full after N, shifter loads at N+1, `tx` low from N+1.
- Frame length = (1 + `Width` + `StopBits`) × 2^`TimerWidth` cycles, measured from the `tx` falling edge. Each bit is exactly 2^`TimerWidth` cycles.
- `finish` is high for the one cycle beginning at frame start + frame length.
- Back-to-back (holding full before frame end): next start bit begins in the cycle immediately after the last stop cycle, with zero gap.
- Throughput: one word per frame length when the producer keeps the holding register full.

## Structure
- Shared package `serial_pkg`:
  - state encoding constants `IDLE`, `START`, `DATA`, `STOP` (2 bits)
  - default `Width`/`TimerWidth` constants, shared with the receiver so both ends agree on the bit period
- One sub-module, `serial_bit_timer`:
  - `TimerWidth`-bit counter with synchronous `clear`
  - outputs `bit_end` in the last cycle of each period
- `serial_tx` holds the FSM, holding register, shifter and bit counter.

## Test plan
Bench parameters: `Width`=8, `TimerWidth`=4 (16-cycle bits), `StopBits`=1.
- Single word: `send` with `D`=0xA5 at edge 10 → `tx` low over edges 11–26, then 1,0,1,0,0,1,0,1 at 16 cycles each, high over 155–170. `finish` high in cycle 171 only. `busy` high from 11 to 171, then low.
- Back-to-back: 0x3C accepted at edge 10, 0xC3 accepted at edge 12 → second start bit begins at edge 171 with no gap. `ready` is 0 over 12–170 and 1 after 171. Two `finish` pulses, 160 cycles apart.
- Same-edge acceptance: `send` 0x55 exactly at the final STOP edge 171 with holding empty → `tx` high in cycle 171, low from 172.
- Backpressure: holding full and `send` held with changing `D` → only the value present on the first `ready`=1 edge is transmitted.
- Reset mid-frame: `rst` at edge 60 during DATA → `tx`=1, `ready`=1, `busy`=0 from edge 61. No `finish`, queued word lost.
- Loopback: `tx` wired to the serial receiver (same `Width`/`TimerWidth`), words 0x00, 0xFF, 0x81 sent back-to-back → receiver presents each value with `finish`, none dropped.
